oam_dma_engine: RTL and testbench
=================================

# oam_dma_engine

Bus-master block sitting directly upstream of the SM83 test memory: owns the memory's read/write ports and arbitrates between the CPU and a Game Boy–style block-copy DMA. When idle, it passes CPU accesses straight through. A CPU write to the DMA register starts a copy of `LEN` bytes from `{page, 8'h00}` to `DST_BASE`. During the copy the CPU is locked off the bus.

## Interface
Parameters:
- `LEN`, 160, bytes per transfer; legal range 1..256.
- `DST_BASE`, 16'hFE00, destination base address.
- `REG_ADDR`, 16'hFF46, CPU address of the DMA start/page register.

Ports (`addr_t` = 16 bit, `data_t` = 8 bit, from `sm83_pkg`):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_r_addr`  in  addr_t  CPU read address.
- `cpu_r_data`  out  data_t  CPU read data.
- `cpu_w_addr`  in  addr_t  CPU write address.
- `cpu_w_data`  in  data_t  CPU write data.
- `cpu_wen`  in  1  CPU write enable.
- `mem_r_addr`  out  addr_t  memory read address; memory read is combinational.
- `mem_r_data`  in  data_t  memory read data, valid in the same cycle as `mem_r_addr`.
- `mem_w_addr`  out  addr_t  memory write address.
- `mem_w_data`  out  data_t  memory write data.
- `mem_wen`  out  1  memory write enable.
- `busy`  out  1  high from START through the final XFER cycle.
- `done`  out  1  one-cycle pulse in the first IDLE cycle after a completed transfer.

## Operation
- State machine: IDLE -> START -> XFER -> IDLE.
- Registers:
  - `page` (8 bit): DMA source page.
  - `idx`: 9 bit, counts 0..LEN.
  - `hold` (data_t): data latch.
- **IDLE behaviour:**
  - `mem_r_addr=cpu_r_addr`, `mem_w_addr=cpu_w_addr`, `mem_w_data=cpu_w_data`, `mem_wen=cpu_wen`.
  - `cpu_r_data=mem_r_data`, except a read of `REG_ADDR`, which returns `page`.
- **Register write:** `cpu_wen && cpu_w_addr==REG_ADDR` in any state:
  - is not forwarded to memory;
  - loads `page<=cpu_w_data` and `idx<=0`;
  - sets next state to START.
- **START:** one dead cycle with no DMA memory access. The bus is still owned by DMA.
- **XFER cycle with index i:**
  - Read side, when i<LEN: `mem_r_addr = {page,8'h00} + i` (16-bit, mod 2^16), and `hold<=mem_r_data`.
  - Write side, when i>=1: `mem_wen=1`, `mem_w_addr = DST_BASE + (i-1)` (mod 2^16), `mem_w_data=hold`.
  - At i==LEN, go to IDLE.
- **CPU while `busy`:**
  - Reads return 8'hFF; read of `REG_ADDR` still returns `page`.
  - Writes to addresses other than `REG_ADDR` are dropped.
- **Restart:** a register write during START or XFER abandons the current copy. No `done` pulse is issued. The block re-enters START with the new page. Bytes already written stay written.
- **Reset:**
  - State goes to IDLE; `page`, `idx` and `hold` clear to 0; `busy=0`, `done=0`.
  - `mem_wen` is forced 0 during any cycle with `rst` high; CPU writes are not forwarded.
  - Reset mid-transfer aborts with no further DMA writes.
- **Outputs when idle and not in reset:** `busy=0`, `done=0`, and the memory outputs mirror the CPU inputs.

## Timing
- Trigger write in cycle T:
  - START in T+1.
  - XFER i=0 in T+2, through i=LEN in T+2+LEN.
  - IDLE with `done=1` in T+3+LEN.
- `busy` is high for exactly LEN+2 cycles.
- Exactly LEN DMA writes, one per cycle, in cycles T+3..T+2+LEN. Write k carries byte k, read one cycle earlier.
- Read-to-write latency is 1 cycle through `hold`. The memory may be the destination of the previous byte's write in the same cycle; source/destination overlap gives no ordering guarantee.
- Idle pass-through path is purely combinational, zero latency.
- `done` and `busy` are registered outputs.

## Test plan
- **Basic copy:** LEN=4; memory[0x0100..0x0103]=11,22,33,44; write 8'h01 to `REG_ADDR` at T -> `busy` high T+1..T+6; writes to `DST_BASE`+0..3 with 11,22,33,44 in T+3..T+6; `done` pulses at T+7.
- **Pass-through:** idle CPU write 0x0005<=AB then read 0x0005 -> memory updated the same edge; `cpu_r_data`=AB; `busy`=0 throughout.
- **CPU lockout:** during XFER, CPU write 0x0002<=55 and read 0x0000 -> no memory write occurs at 0x0002; the read returns FF; a `REG_ADDR` read returns `page`.
- **Restart:** rewrite `REG_ADDR` with 8'h02 at XFER i=2 -> no `done` pulse; START next cycle; the full LEN bytes are copied from 0x0200; total `busy` count resets.
- **Reset mid-transfer:** assert `rst` at XFER i=1 for 1 cycle -> `mem_wen`=0 in that cycle and after; `busy`=0 and `done`=0 the next cycle; `REG_ADDR` read returns 00.
- **Wrap/LEN=256:** page=8'hFF, DST_BASE=16'hFF80 -> source addresses FF00..FFFF; destination wraps to 0x0000..0x007F after 0xFFFF; exactly 256 writes.

Source files
------------

// File: rtl/oam_dma_engine.sv
// Bus master in front of the SM83 test memory: passes CPU accesses through when idle
// and runs a Game Boy style page-to-DST_BASE block copy with the CPU locked off the bus.
package sm83_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module oam_dma_engine
  import sm83_pkg::*;
#(
  parameter int unsigned LEN      = 160,
  parameter logic [15:0] DST_BASE = 16'hFE00,
  parameter logic [15:0] REG_ADDR = 16'hFF46
) (
  input  logic  clk,
  input  logic  rst,
  input  addr_t cpu_r_addr,
  output data_t cpu_r_data,
  input  addr_t cpu_w_addr,
  input  data_t cpu_w_data,
  input  logic  cpu_wen,
  output addr_t mem_r_addr,
  input  data_t mem_r_data,
  output addr_t mem_w_addr,
  output data_t mem_w_data,
  output logic  mem_wen,
  output logic  busy,
  output logic  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  localparam logic [8:0] LEN_C = 9'(LEN);

  state_e     state_q, state_d;
  data_t      page_q, page_d;
  data_t      hold_q, hold_d;
  logic [8:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       reg_wr_s;
  logic       reg_rd_s;
  logic       last_s;
  addr_t      src_addr_s;
  addr_t      dst_addr_s;

  assign reg_wr_s   = cpu_wen && (cpu_w_addr == REG_ADDR);
  assign reg_rd_s   = (cpu_r_addr == REG_ADDR);
  assign last_s     = (idx_q == LEN_C);
  assign src_addr_s = {page_q, 8'h00} + {7'd0, idx_q};
  // Write side lags the read side by one index; idx 0 never writes, so the -1 never matters there.
  assign dst_addr_s = DST_BASE + {7'd0, idx_q} - 16'd1;

  // Next-state logic for the copy sequencer and its data latch.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_XFER;
        idx_d   = 9'd0;
      end
      ST_XFER: begin
        if (idx_q < LEN_C) begin
          hold_d = mem_r_data;
        end else begin
          hold_d = hold_q;
        end
        if (last_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 9'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A register write wins over everything, including the final transfer cycle.
    if (reg_wr_s) begin
      state_d = ST_START;
      page_d  = cpu_w_data;
      idx_d   = 9'd0;
      done_d  = 1'b0;
    end else begin
      page_d = page_d;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      hold_q  <= 8'h00;
      idx_q   <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Bus ownership: CPU pass-through when idle, DMA addresses otherwise.
  always_comb begin
    mem_r_addr = cpu_r_addr;
    mem_w_addr = cpu_w_addr;
    mem_w_data = cpu_w_data;
    mem_wen    = 1'b0;
    cpu_r_data = mem_r_data;
    case (state_q)
      ST_IDLE: begin
        mem_wen = cpu_wen && !reg_wr_s;
      end
      ST_START: begin
        mem_r_addr = src_addr_s;
        mem_w_addr = dst_addr_s;
        mem_w_data = hold_q;
        cpu_r_data = 8'hFF;
      end
      ST_XFER: begin
        mem_r_addr = src_addr_s;
        mem_w_addr = dst_addr_s;
        mem_w_data = hold_q;
        mem_wen    = (idx_q != 9'd0);
        cpu_r_data = 8'hFF;
      end
      default: begin
        mem_wen = 1'b0;
      end
    endcase
    if (reg_rd_s) begin
      cpu_r_data = page_q;
    end else begin
      cpu_r_data = cpu_r_data;
    end
    if (rst) begin
      mem_wen = 1'b0;
    end else begin
      mem_wen = mem_wen;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: two instances (LEN=4 at FE00, LEN=256 at FF80),
// a bench-owned memory per instance, and a copy-level reference model.
module tb_oam_dma_engine;

  localparam logic [15:0] REG = 16'hFF46;

  typedef struct { int cyc; logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic [7:0] d; } rd_t;
  typedef struct { int start; int stop; logic done; } run_t;

  logic        clk;
  logic        rst_s        [2];
  logic [15:0] cpu_r_addr_s [2];
  logic [7:0]  cpu_r_data_s [2];
  logic [15:0] cpu_w_addr_s [2];
  logic [7:0]  cpu_w_data_s [2];
  logic        cpu_wen_s    [2];
  logic [15:0] mem_r_addr_s [2];
  logic [7:0]  mem_r_data_s [2];
  logic [15:0] mem_w_addr_s [2];
  logic [7:0]  mem_w_data_s [2];
  logic        mem_wen_s    [2];
  logic        busy_s       [2];
  logic        done_s       [2];

  logic [7:0]  mem     [2][65536];
  logic [7:0]  ref_mem [2][65536];
  logic        load_s = 1'b1;

  wr_t  exp_wr  [2][$];
  rd_t  exp_rd  [2][$];
  run_t exp_run [2][$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;
  logic rd_chk [2];

  logic       in_run    [2];
  int         run_start [2];
  int         last_trig [2];
  logic [7:0] page_m    [2];

  oam_dma_engine #(.LEN(4)) u_dut_a (
    .clk(clk), .rst(rst_s[0]),
    .cpu_r_addr(cpu_r_addr_s[0]), .cpu_r_data(cpu_r_data_s[0]),
    .cpu_w_addr(cpu_w_addr_s[0]), .cpu_w_data(cpu_w_data_s[0]), .cpu_wen(cpu_wen_s[0]),
    .mem_r_addr(mem_r_addr_s[0]), .mem_r_data(mem_r_data_s[0]),
    .mem_w_addr(mem_w_addr_s[0]), .mem_w_data(mem_w_data_s[0]), .mem_wen(mem_wen_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  oam_dma_engine #(.LEN(256), .DST_BASE(16'hFF80)) u_dut_b (
    .clk(clk), .rst(rst_s[1]),
    .cpu_r_addr(cpu_r_addr_s[1]), .cpu_r_data(cpu_r_data_s[1]),
    .cpu_w_addr(cpu_w_addr_s[1]), .cpu_w_data(cpu_w_data_s[1]), .cpu_wen(cpu_wen_s[1]),
    .mem_r_addr(mem_r_addr_s[1]), .mem_r_data(mem_r_data_s[1]),
    .mem_w_addr(mem_w_addr_s[1]), .mem_w_data(mem_w_data_s[1]), .mem_wen(mem_wen_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_r_data_s[0] = mem[0][mem_r_addr_s[0]];
  assign mem_r_data_s[1] = mem[1][mem_r_addr_s[1]];

  // Bench memories: preloaded from the reference image, then written by the DUT.
  always @(posedge clk) begin
    if (load_s) begin
      for (int a = 0; a < 65536; a++) begin
        mem[0][a] <= ref_mem[0][a];
        mem[1][a] <= ref_mem[1][a];
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (mem_wen_s[u]) mem[u][mem_w_addr_s[u]] <= mem_w_data_s[u];
      end
    end
  end

  function automatic int len_m(input int u);
    return (u == 0) ? 4 : 256;
  endfunction

  function automatic logic [15:0] dst_m(input int u);
    return (u == 0) ? 16'hFE00 : 16'hFF80;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT writes, a read is flagged, or busy falls.
  always @(negedge clk) begin : mon
    logic prev_busy [2];
    int   obs_start [2];
    wr_t  w;
    rd_t  r;
    run_t rn;
    int   bad;
    if (!mon_en) begin
      prev_busy[0] = 1'b0;
      prev_busy[1] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (rst_s[u]) begin
          checks++;
          if (mem_wen_s[u]) begin
            errors++;
            $display("FAIL rst_wen u=%0d cyc=%0d got mem_wen=1 want 0", u, cyc);
          end
        end else if (mem_wen_s[u]) begin
          checks++;
          if (exp_wr[u].size() == 0) begin
            errors++;
            $display("FAIL unexpected_write u=%0d cyc=%0d got %h<=%h want none", u, cyc, mem_w_addr_s[u], mem_w_data_s[u]);
          end else begin
            w = exp_wr[u].pop_front();
            if (w.cyc != cyc || w.a != mem_w_addr_s[u] || w.d != mem_w_data_s[u]) begin
              errors++;
              $display("FAIL mem_write u=%0d got cyc=%0d %h<=%h want cyc=%0d %h<=%h",
                       u, cyc, mem_w_addr_s[u], mem_w_data_s[u], w.cyc, w.a, w.d);
            end
          end
        end
        if (rd_chk[u]) begin
          checks++;
          r = exp_rd[u].pop_front();
          if (r.cyc != cyc || r.d != cpu_r_data_s[u]) begin
            errors++;
            $display("FAIL cpu_read u=%0d cyc=%0d addr=%h got %h want %h (exp cyc %0d)",
                     u, cyc, cpu_r_addr_s[u], cpu_r_data_s[u], r.d, r.cyc);
          end
        end
        if (busy_s[u] && !prev_busy[u]) obs_start[u] = cyc;
        if (!busy_s[u] && prev_busy[u]) begin
          checks++;
          if (exp_run[u].size() == 0) begin
            errors++;
            $display("FAIL busy_run u=%0d got run %0d..%0d want none", u, obs_start[u], cyc - 1);
          end else begin
            rn = exp_run[u].pop_front();
            if (rn.start != obs_start[u] || rn.stop != cyc - 1 || rn.done != done_s[u]) begin
              errors++;
              $display("FAIL busy_run u=%0d got %0d..%0d done=%0d want %0d..%0d done=%0d",
                       u, obs_start[u], cyc - 1, done_s[u], rn.start, rn.stop, rn.done);
            end
          end
        end else if (done_s[u]) begin
          checks++;
          errors++;
          $display("FAIL spurious_done u=%0d cyc=%0d got done=1 want 0", u, cyc);
        end
        prev_busy[u] = busy_s[u];
      end
      if (end_req && !end_done) begin
        for (int u = 0; u < 2; u++) begin
          checks++;
          if (exp_wr[u].size() != 0 || exp_run[u].size() != 0) begin
            errors++;
            $display("FAIL pending u=%0d got writes=%0d runs=%0d left want 0 0", u, exp_wr[u].size(), exp_run[u].size());
          end
          bad = 0;
          for (int a = 0; a < 65536; a++) begin
            if (mem[u][a] != ref_mem[u][a]) begin
              if (bad == 0) $display("FAIL mem_image u=%0d addr=%h got %h want %h", u, a, mem[u][a], ref_mem[u][a]);
              bad++;
            end
          end
          checks++;
          if (bad != 0) errors++;
        end
        end_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle; reads are predicted before this cycle's write lands.
  task automatic cpu_cycle(input int u, input logic wen, input logic [15:0] wa,
                           input logic [7:0] wd, input logic [15:0] ra, input logic chk);
    logic       busy_m;
    logic [7:0] rexp;
    busy_m = in_run[u] && (cyc >= run_start[u]);
    if (ra == REG)   rexp = page_m[u];
    else if (busy_m) rexp = 8'hFF;
    else             rexp = ref_mem[u][ra];
    if (chk) exp_rd[u].push_back('{cyc: cyc, d: rexp});
    if (wen && !busy_m && wa != REG) begin
      exp_wr[u].push_back('{cyc: cyc, a: wa, d: wd});
      ref_mem[u][wa] = wd;
    end
    cpu_wen_s[u] = wen; cpu_w_addr_s[u] = wa; cpu_w_data_s[u] = wd;
    cpu_r_addr_s[u] = ra; rd_chk[u] = chk;
    tick();
    cpu_wen_s[u] = 1'b0; rd_chk[u] = 1'b0;
  endtask

  task automatic wait_until(input int u, input int c);
    while (cyc < c) cpu_cycle(u, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0);
  endtask

  // Trigger a copy; nwr is how many bytes will land before the copy ends or is cut short.
  // Byte k is read while writes of bytes 0..k-2 are already in memory.
  task automatic dma_start(input int u, input logic [7:0] page, input int nwr);
    int          t;
    logic [15:0] dst;
    logic [15:0] s;
    int          dd;
    logic [7:0]  v;
    logic [7:0]  dat [$];
    t = cyc;
    dst = dst_m(u);
    for (int k = 0; k < nwr; k++) begin
      s  = {page, 8'h00} + 16'(k);
      dd = int'(16'(s - dst));
      if (k >= 2 && dd <= k - 2) v = dat[dd];
      else                       v = ref_mem[u][s];
      dat.push_back(v);
      exp_wr[u].push_back('{cyc: t + 3 + k, a: 16'(dst + 16'(k)), d: v});
    end
    for (int k = 0; k < nwr; k++) ref_mem[u][16'(dst + 16'(k))] = dat[k];
    if (!in_run[u]) begin
      in_run[u] = 1'b1;
      run_start[u] = t + 1;
    end
    last_trig[u] = t;
    page_m[u] = page;
    cpu_wen_s[u] = 1'b1; cpu_w_addr_s[u] = REG; cpu_w_data_s[u] = page;
    tick();
    cpu_wen_s[u] = 1'b0;
  endtask

  task automatic dma_finish(input int u);
    int stop;
    stop = last_trig[u] + 2 + len_m(u);
    exp_run[u].push_back('{start: run_start[u], stop: stop, done: 1'b1});
    wait_until(u, stop + 3);
    in_run[u] = 1'b0;
  endtask

  task automatic dma_reset(input int u);
    exp_run[u].push_back('{start: run_start[u], stop: cyc, done: 1'b0});
    rst_s[u] = 1'b1;
    tick();
    rst_s[u] = 1'b0;
    in_run[u] = 1'b0;
    page_m[u] = 8'h00;
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 65535));
    if (a == REG) a = a ^ 16'h0001;
    return a;
  endfunction

  initial begin
    int t;
    int dly;
    int n;
    logic [7:0] p;
    for (int u = 0; u < 2; u++) begin
      rst_s[u] = 1'b1; cpu_wen_s[u] = 1'b0; cpu_w_addr_s[u] = 16'h0000;
      cpu_w_data_s[u] = 8'h00; cpu_r_addr_s[u] = 16'h0000; rd_chk[u] = 1'b0;
      in_run[u] = 1'b0; run_start[u] = 0; last_trig[u] = 0; page_m[u] = 8'h00;
      for (int a = 0; a < 65536; a++) ref_mem[u][a] = 8'($urandom);
    end
    tick();
    load_s = 1'b0;
    tick(); tick();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    mon_en = 1'b1;

    // Reset state: page register reads 00, idle reads see memory.
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, REG, 1'b1);
    cpu_cycle(1, 1'b0, 16'h0000, 8'h00, REG, 1'b1);
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, 16'h1234, 1'b1);

    // Basic copy of 11,22,33,44 from page 01.
    cpu_cycle(0, 1'b1, 16'h0100, 8'h11, 16'h0000, 1'b0);
    cpu_cycle(0, 1'b1, 16'h0101, 8'h22, 16'h0000, 1'b0);
    cpu_cycle(0, 1'b1, 16'h0102, 8'h33, 16'h0000, 1'b0);
    cpu_cycle(0, 1'b1, 16'h0103, 8'h44, 16'h0000, 1'b0);
    dma_start(0, 8'h01, 4);
    dma_finish(0);
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, 16'hFE02, 1'b1);

    // Pass-through write then read back.
    cpu_cycle(0, 1'b1, 16'h0005, 8'hAB, 16'h0000, 1'b0);
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, 16'h0005, 1'b1);

    // Lockout during XFER.
    t = cyc;
    dma_start(0, 8'h03, 4);
    wait_until(0, t + 3);
    cpu_cycle(0, 1'b1, 16'h0002, 8'h55, 16'h0000, 1'b1);
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, REG, 1'b1);
    dma_finish(0);
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, 16'h0002, 1'b1);

    // Restart at XFER i=2 with page 02.
    t = cyc;
    dma_start(0, 8'h01, 2);
    wait_until(0, t + 4);
    dma_start(0, 8'h02, 4);
    dma_finish(0);

    // Reset at XFER i=1.
    t = cyc;
    dma_start(0, 8'h05, 0);
    wait_until(0, t + 3);
    dma_reset(0);
    cpu_cycle(0, 1'b0, 16'h0000, 8'h00, REG, 1'b1);

    // LEN=256 from page FF into FF80, wrapping past FFFF.
    dma_start(1, 8'hFF, 256);
    dma_finish(1);
    cpu_cycle(1, 1'b0, 16'h0000, 8'h00, 16'h0010, 1'b1);

    // Randomized mix per instance.
    for (int u = 0; u < 2; u++) begin
      for (int it = 0; it < ((u == 0) ? 60 : 20); it++) begin
        case ($urandom_range(0, 3))
          0: cpu_cycle(u, 1'b1, rnd_addr(), 8'($urandom), rnd_addr(), 1'b1);
          1: cpu_cycle(u, 1'b0, 16'h0000, 8'h00, ($urandom_range(0, 3) == 0) ? REG : rnd_addr(), 1'b1);
          2: begin
            p = (u == 0) ? 8'($urandom_range(0, 253)) : 8'($urandom_range(1, 254));
            dma_start(u, p, len_m(u));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++)
              cpu_cycle(u, 1'($urandom), rnd_addr(), 8'($urandom),
                        ($urandom_range(0, 2) == 0) ? REG : rnd_addr(), 1'b1);
            dma_finish(u);
          end
          default: begin
            t = cyc;
            dly = $urandom_range(1, len_m(u) + 2);
            p = (u == 0) ? 8'($urandom_range(0, 253)) : 8'($urandom_range(1, 254));
            dma_start(u, p, (dly > 2) ? dly - 2 : 0);
            wait_until(u, t + dly);
            p = (u == 0) ? 8'($urandom_range(0, 253)) : 8'($urandom_range(1, 254));
            dma_start(u, p, len_m(u));
            dma_finish(u);
          end
        endcase
      end
    end

    end_req = 1'b1;
    repeat (3) @(posedge clk);
    if (!end_done) begin
      $display("FAIL end_check got not run want run");
      $fatal(1, "end check did not execute");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
